// File: rtl/adam_block_sequencer.sv
// Splits a 1 KB Adam block request into two 512-byte sector operations on the
// sector cache and moves the bytes to or from the host block buffer.
module adam_block_sequencer #(
    parameter logic [23:0] TIMEOUT   = 24'd8_000_000,
    parameter int          DRIVE_NUM = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_block,
    input  logic [31:0] disk_blocks,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  buf_addr,
    output logic        buf_we,
    output logic [7:0]  buf_dout,
    input  logic [7:0]  buf_din,
    input  logic        disk_present,
    output logic [31:0] disk_sector,
    output logic        disk_load,
    input  logic        disk_sector_loaded,
    output logic [8:0]  disk_addr,
    output logic        disk_wr,
    output logic [7:0]  disk_din,
    output logic        disk_flush,
    input  logic        disk_flushed,
    input  logic [7:0]  disk_data
);
    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_PRE_FLUSH, S_WAIT_PRE, S_LOAD,
        S_WAIT_REL, S_XFER, S_WAIT_POST, S_NEXT
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [31:0] block_q, block_d;
    logic        sec_q, sec_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [23:0] timer_q, timer_d;
    logic        dirty_q, dirty_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [9:0]  buf_addr_q, buf_addr_d;
    logic        buf_we_q, buf_we_d;
    logic [7:0]  buf_dout_q, buf_dout_d;
    logic [31:0] disk_sector_q, disk_sector_d;
    logic        disk_load_q, disk_load_d;
    logic [8:0]  disk_addr_q, disk_addr_d;
    logic        disk_wr_q, disk_wr_d;
    logic [7:0]  disk_din_q, disk_din_d;
    logic        disk_flush_q, disk_flush_d;
    logic        timeout_s;
    logic [8:0]  prev_s;
    logic        unused_drive_s;

    assign unused_drive_s = (DRIVE_NUM == 0);
    assign timeout_s      = ((timer_q + 24'd1) == TIMEOUT);
    // Byte index whose cache/buffer data arrives this cycle (one behind the address counter)
    assign prev_s         = cnt_q[8:0] - 9'd1;

    // Next-state and next-output computation
    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        block_d       = block_q;
        sec_d         = sec_q;
        cnt_d         = cnt_q;
        dirty_d       = dirty_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_we_d      = 1'b0;
        buf_dout_d    = buf_dout_q;
        disk_sector_d = disk_sector_q;
        disk_load_d   = disk_load_q;
        disk_addr_d   = disk_addr_q;
        disk_wr_d     = 1'b0;
        disk_din_d    = disk_din_q;
        disk_flush_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_rd || req_wr) begin
                    dir_d   = ~req_rd;
                    block_d = req_block;
                    busy_d  = 1'b1;
                    sec_d   = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!disk_present || (block_q >= disk_blocks)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    disk_sector_d = {block_q[30:0], sec_q};
                    disk_flush_d  = 1'b1;
                    state_d       = S_PRE_FLUSH;
                end
            end
            S_PRE_FLUSH: begin
                if (dirty_q) begin
                    state_d = S_WAIT_PRE;
                end else begin
                    disk_load_d = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_WAIT_PRE: begin
                if (disk_flushed) begin
                    dirty_d     = 1'b0;
                    disk_load_d = 1'b1;
                    state_d     = S_LOAD;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    dirty_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_PRE;
                end
            end
            S_LOAD: begin
                if (disk_sector_loaded) begin
                    disk_load_d = 1'b0;
                    state_d     = S_WAIT_REL;
                end else if (timeout_s) begin
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                    dirty_d     = 1'b0;
                    disk_load_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WAIT_REL: begin
                if (disk_flushed) begin
                    cnt_d       = 10'd0;
                    disk_addr_d = 9'd0;
                    buf_addr_d  = {sec_q, 9'd0};
                    state_d     = S_XFER;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    dirty_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            S_XFER: begin
                cnt_d = cnt_q + 10'd1;
                if (!dir_q) begin
                    disk_addr_d = cnt_q[8:0] + 9'd1;
                    if (cnt_q != 10'd0) begin
                        buf_we_d   = 1'b1;
                        buf_addr_d = {sec_q, prev_s};
                        buf_dout_d = disk_data;
                    end else begin
                        buf_we_d = 1'b0;
                    end
                    state_d = (cnt_q == 10'd512) ? S_NEXT : S_XFER;
                end else if (cnt_q == 10'd513) begin
                    // Last cache write has landed; push the sector back to the image
                    disk_flush_d = 1'b1;
                    state_d      = S_WAIT_POST;
                end else begin
                    buf_addr_d = {sec_q, cnt_q[8:0] + 9'd1};
                    if (cnt_q != 10'd0) begin
                        disk_wr_d   = 1'b1;
                        disk_addr_d = prev_s;
                        disk_din_d  = buf_din;
                        dirty_d     = 1'b1;
                    end else begin
                        disk_wr_d = 1'b0;
                    end
                end
            end
            S_WAIT_POST: begin
                if (disk_flushed) begin
                    dirty_d = 1'b0;
                    state_d = S_NEXT;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    dirty_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_POST;
                end
            end
            S_NEXT: begin
                if (!sec_q) begin
                    sec_d   = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        timer_d = (state_d != state_q) ? 24'd0 : (timer_q + 24'd1);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            dir_q         <= 1'b0;
            block_q       <= 32'd0;
            sec_q         <= 1'b0;
            cnt_q         <= 10'd0;
            timer_q       <= 24'd0;
            dirty_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            buf_addr_q    <= 10'd0;
            buf_we_q      <= 1'b0;
            buf_dout_q    <= 8'd0;
            disk_sector_q <= 32'd0;
            disk_load_q   <= 1'b0;
            disk_addr_q   <= 9'd0;
            disk_wr_q     <= 1'b0;
            disk_din_q    <= 8'd0;
            disk_flush_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            block_q       <= block_d;
            sec_q         <= sec_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            dirty_q       <= dirty_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            buf_addr_q    <= buf_addr_d;
            buf_we_q      <= buf_we_d;
            buf_dout_q    <= buf_dout_d;
            disk_sector_q <= disk_sector_d;
            disk_load_q   <= disk_load_d;
            disk_addr_q   <= disk_addr_d;
            disk_wr_q     <= disk_wr_d;
            disk_din_q    <= disk_din_d;
            disk_flush_q  <= disk_flush_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign buf_addr    = buf_addr_q;
    assign buf_we      = buf_we_q;
    assign buf_dout    = buf_dout_q;
    assign disk_sector = disk_sector_q;
    assign disk_load   = disk_load_q;
    assign disk_addr   = disk_addr_q;
    assign disk_wr     = disk_wr_q;
    assign disk_din    = disk_din_q;
    assign disk_flush  = disk_flush_q;
endmodule

// File: tb/tb_adam_block_sequencer.sv
// Directed bench for adam_block_sequencer: sector cache model with load/flush
// handshake, host buffer model and a backing disk image.
module tb_adam_block_sequencer;
    localparam int BACK = 40 * 512;

    logic        clk = 1'b0;
    logic        reset, req_rd, req_wr, disk_present;
    logic [31:0] req_block, disk_blocks;
    logic        busy, done, err, buf_we, disk_load, disk_wr, disk_flush;
    logic [9:0]  buf_addr;
    logic [7:0]  buf_dout, disk_din;
    logic [7:0]  buf_din = 8'd0, disk_data = 8'd0;
    logic [31:0] disk_sector;
    logic [8:0]  disk_addr;
    logic        disk_sector_loaded = 1'b0, disk_flushed = 1'b0;
    logic [73:0] all_out;

    logic [7:0]  backing [0:BACK-1];
    logic [7:0]  cache   [0:511];
    logic [7:0]  hbuf    [0:1023];
    logic [7:0]  wsrc    [0:1023];
    logic        fill = 1'b0, clr_buf = 1'b0, stall = 1'b0;
    logic        cdirty = 1'b0;
    logic [1:0]  mstate = 2'd0;
    int          mcnt = 0, mlba = 0, wb_cnt = 0;

    int          done_cnt = 0, err_cnt = 0, load_rises = 0, lcnt = 0, gap = 0, gap_bad = 0, viol = 0;
    logic        load_prev = 1'b0, pend = 1'b0;
    logic [31:0] lba_log [0:63];

    int          nvec = 0, nmis = 0;

    adam_block_sequencer #(.TIMEOUT(24'd100), .DRIVE_NUM(0)) dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_block(req_block),
        .disk_blocks(disk_blocks), .busy(busy), .done(done), .err(err),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_dout(buf_dout), .buf_din(buf_din),
        .disk_present(disk_present), .disk_sector(disk_sector), .disk_load(disk_load),
        .disk_sector_loaded(disk_sector_loaded), .disk_addr(disk_addr), .disk_wr(disk_wr),
        .disk_din(disk_din), .disk_flush(disk_flush), .disk_flushed(disk_flushed),
        .disk_data(disk_data)
    );

    assign all_out = {busy, done, err, buf_addr, buf_we, buf_dout, disk_sector,
                      disk_load, disk_addr, disk_wr, disk_din, disk_flush};

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'((a >>> 9) * 37 + (a & 511) * 5 + (a >>> 8));
    endfunction

    // Sector cache, host buffer and disk image models
    always @(posedge clk) begin
        disk_data    <= cache[disk_addr];
        buf_din      <= wsrc[buf_addr];
        disk_flushed <= 1'b0;
        if (fill) for (int j = 0; j < BACK; j++) backing[j] <= pat(j);
        if (clr_buf) for (int j = 0; j < 1024; j++) hbuf[j] <= 8'h00;
        else if (buf_we) hbuf[buf_addr] <= buf_dout;
        if (disk_wr) begin
            cache[disk_addr] <= disk_din;
            cdirty <= 1'b1;
        end
        case (mstate)
            2'd0: begin
                if (disk_flush) begin
                    disk_sector_loaded <= 1'b0;
                    if (cdirty) begin mstate <= 2'd3; mcnt <= 3; end
                end else if (disk_load && !disk_sector_loaded && !stall) begin
                    mstate <= 2'd1; mcnt <= 4; mlba <= int'(disk_sector);
                end
            end
            2'd1: begin
                if (mcnt == 0) begin
                    for (int j = 0; j < 512; j++)
                        if (mlba * 512 + j < BACK) cache[j] <= backing[mlba * 512 + j];
                    disk_sector_loaded <= 1'b1;
                    mstate <= 2'd2;
                end else mcnt <= mcnt - 1;
            end
            2'd2: begin
                if (!disk_load) begin disk_flushed <= 1'b1; mstate <= 2'd0; end
            end
            default: begin
                if (mcnt == 0) begin
                    for (int j = 0; j < 512; j++)
                        if (mlba * 512 + j < BACK) backing[mlba * 512 + j] <= cache[j];
                    cdirty <= 1'b0; wb_cnt <= wb_cnt + 1; disk_flushed <= 1'b1; mstate <= 2'd0;
                end else mcnt <= mcnt - 1;
            end
        endcase
    end

    // Pulse counters, load log, flush-to-load gap and protocol monitor
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        load_prev <= disk_load;
        if (disk_load && !load_prev) begin
            load_rises <= load_rises + 1;
            lba_log[lcnt[5:0]] <= disk_sector;
            lcnt <= lcnt + 1;
        end
        if (disk_flush) begin
            pend <= 1'b1; gap <= 0;
        end else if (pend) begin
            if (disk_load) begin
                if (gap + 1 != 1) gap_bad <= gap_bad + 1;
                pend <= 1'b0;
            end else gap <= gap + 1;
        end
        if ((disk_flush && disk_load) || (disk_wr && disk_load) || (done && err)) viol <= viol + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_req(input logic rd, input logic wr, input logic [31:0] blk);
        req_rd = rd; req_wr = wr; req_block = blk;
        tick();
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic clear_hbuf();
        clr_buf = 1'b1; tick(); clr_buf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        nvec++; if (all_out !== 74'd0) begin nmis++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        reset = 1'b0;
        tick();
        nvec++; if (all_out !== 74'd0) begin nmis++; $display("FAIL idle_outputs: got %h want 0", all_out); end
    endtask

    task automatic test_read();
        int d0, e0, l0, g0, bad; bit ok;
        clear_hbuf();
        d0 = done_cnt; e0 = err_cnt; l0 = lcnt; g0 = gap_bad;
        pulse_req(1'b1, 1'b0, 32'd5);
        nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL read_busy: got %b want 1", busy); end
        wait_idle(4000, ok);
        nvec++; if (!ok) begin nmis++; $display("FAIL read_complete: got busy want idle"); end
        tick();
        nvec++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin nmis++; $display("FAIL read_pulses: got done=%0d err=%0d want 1/0", done_cnt - d0, err_cnt - e0); end
        nvec++; if (lcnt - l0 !== 2 || lba_log[l0[5:0]] !== 32'd10 || lba_log[6'(l0 + 1)] !== 32'd11) begin
            nmis++; $display("FAIL read_lbas: got n=%0d %0d,%0d want 2 10,11", lcnt - l0, lba_log[l0[5:0]], lba_log[6'(l0 + 1)]);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (hbuf[i] !== pat(10 * 512 + i)) bad++;
        nvec++; if (bad !== 0) begin nmis++; $display("FAIL read_data: got %0d bad bytes want 0", bad); end
        nvec++; if (gap_bad !== g0) begin nmis++; $display("FAIL read_no_wait_pre: got %0d slow loads want 0", gap_bad - g0); end
    endtask

    task automatic test_write();
        int d0, w0, g0, bad; bit ok;
        for (int i = 0; i < 1024; i++) wsrc[i] = 8'(i);
        d0 = done_cnt; w0 = wb_cnt; g0 = gap_bad;
        pulse_req(1'b0, 1'b1, 32'd3);
        wait_idle(4000, ok);
        tick();
        nvec++; if (!ok || done_cnt - d0 !== 1) begin nmis++; $display("FAIL write_done: got ok=%0b done=%0d want 1/1", ok, done_cnt - d0); end
        nvec++; if (wb_cnt - w0 !== 2) begin nmis++; $display("FAIL write_flushes: got %0d want 2", wb_cnt - w0); end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (backing[6 * 512 + i] !== 8'(i)) bad++;
        nvec++; if (bad !== 0) begin nmis++; $display("FAIL write_data: got %0d bad bytes want 0", bad); end
        for (int i = 0; i < 1024; i++) wsrc[i] = 8'(i * 7 + 1);
        d0 = done_cnt; w0 = wb_cnt;
        pulse_req(1'b0, 1'b1, 32'd4);
        wait_idle(4000, ok);
        tick();
        nvec++; if (!ok || done_cnt - d0 !== 1 || wb_cnt - w0 !== 2) begin nmis++; $display("FAIL write2_done: got ok=%0b done=%0d wb=%0d want 1/1/2", ok, done_cnt - d0, wb_cnt - w0); end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (backing[8 * 512 + i] !== 8'(i * 7 + 1)) bad++;
        nvec++; if (bad !== 0) begin nmis++; $display("FAIL write2_data: got %0d bad bytes want 0", bad); end
        nvec++; if (gap_bad !== g0) begin nmis++; $display("FAIL write_no_wait_pre: got %0d slow loads want 0", gap_bad - g0); end
    endtask

    task automatic test_range();
        int d0, lr0, e0;
        d0 = done_cnt; lr0 = load_rises;
        pulse_req(1'b1, 1'b0, 32'd160);
        nvec++; if (busy !== 1'b1 || err !== 1'b0) begin nmis++; $display("FAIL range_accept: got busy=%b err=%b want 1/0", busy, err); end
        tick();
        nvec++; if (err !== 1'b1 || busy !== 1'b0) begin nmis++; $display("FAIL range_err: got err=%b busy=%b want 1/0", err, busy); end
        tick();
        nvec++; if (err !== 1'b0) begin nmis++; $display("FAIL range_err_pulse: got %b want 0", err); end
        e0 = err_cnt;
        pulse_req(1'b1, 1'b0, 32'hFFFF_FFFF);
        repeat (3) tick();
        nvec++; if (err_cnt - e0 !== 1) begin nmis++; $display("FAIL range_max_block: got %0d errs want 1", err_cnt - e0); end
        disk_present = 1'b0;
        e0 = err_cnt;
        pulse_req(1'b1, 1'b0, 32'd0);
        tick();
        nvec++; if (err !== 1'b1) begin nmis++; $display("FAIL no_disk_err: got %b want 1", err); end
        repeat (2) tick();
        disk_present = 1'b1;
        nvec++; if (err_cnt - e0 !== 1 || done_cnt !== d0 || load_rises !== lr0) begin
            nmis++; $display("FAIL range_side_effects: got err=%0d done=%0d loads=%0d want 1/0/0", err_cnt - e0, done_cnt - d0, load_rises - lr0);
        end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        stall = 1'b1;
        pulse_req(1'b1, 1'b0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (disk_load) begin ok = 1'b1; break; end
            tick();
        end
        nvec++; if (!ok) begin nmis++; $display("FAIL timeout_load: got no disk_load want disk_load"); end
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick(); n++;
            if (err) break;
        end
        nvec++; if (n !== 100) begin nmis++; $display("FAIL timeout_cycles: got %0d want 100", n); end
        nvec++; if (disk_load !== 1'b0 || busy !== 1'b0) begin nmis++; $display("FAIL timeout_release: got load=%b busy=%b want 0/0", disk_load, busy); end
        stall = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_priority();
        int d0, w0, l0, bad; bit ok;
        clear_hbuf();
        d0 = done_cnt; w0 = wb_cnt; l0 = lcnt;
        pulse_req(1'b1, 1'b1, 32'd2);
        repeat (5) tick();
        pulse_req(1'b0, 1'b1, 32'd1);
        wait_idle(4000, ok);
        repeat (20) tick();
        nvec++; if (!ok || done_cnt - d0 !== 1 || wb_cnt !== w0) begin nmis++; $display("FAIL prio_read: got ok=%0b done=%0d wb=%0d want 1/1/0", ok, done_cnt - d0, wb_cnt - w0); end
        nvec++; if (busy !== 1'b0 || lcnt - l0 !== 2 || lba_log[l0[5:0]] !== 32'd4) begin
            nmis++; $display("FAIL prio_ignored: got busy=%b loads=%0d lba=%0d want 0/2/4", busy, lcnt - l0, lba_log[l0[5:0]]);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (hbuf[i] !== pat(4 * 512 + i)) bad++;
        nvec++; if (bad !== 0) begin nmis++; $display("FAIL prio_data: got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int d0, e0, l0, bad; bit ok;
        for (int i = 0; i < 1024; i++) wsrc[i] = 8'(i) ^ 8'hA5;
        pulse_req(1'b0, 1'b1, 32'd9);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (disk_wr) begin ok = 1'b1; break; end
        end
        nvec++; if (!ok) begin nmis++; $display("FAIL mid_xfer_reach: got no disk_wr want disk_wr"); end
        repeat (10) tick();
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b1;
        tick();
        nvec++; if (all_out !== 74'd0) begin nmis++; $display("FAIL mid_reset_outputs: got %h want 0", all_out); end
        reset = 1'b0;
        repeat (5) tick();
        nvec++; if (done_cnt !== d0 || err_cnt !== e0) begin nmis++; $display("FAIL mid_reset_pulses: got done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0); end
        clear_hbuf();
        d0 = done_cnt; l0 = lcnt;
        pulse_req(1'b1, 1'b0, 32'd8);
        wait_idle(4000, ok);
        tick();
        nvec++; if (!ok || done_cnt - d0 !== 1 || lba_log[l0[5:0]] !== 32'd16 || lba_log[6'(l0 + 1)] !== 32'd17) begin
            nmis++; $display("FAIL post_reset_read: got ok=%0b done=%0d lbas=%0d,%0d want 1/1/16,17", ok, done_cnt - d0, lba_log[l0[5:0]], lba_log[6'(l0 + 1)]);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (hbuf[i] !== pat(16 * 512 + i)) bad++;
        nvec++; if (bad !== 0) begin nmis++; $display("FAIL post_reset_data: got %0d bad bytes want 0", bad); end
    endtask

    initial begin
        reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_block = 32'd0;
        disk_present = 1'b1; disk_blocks = 32'd160;
        fill = 1'b1;
        tick();
        fill = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_range();
        test_timeout();
        test_priority();
        test_reset_mid();
        nvec++; if (viol !== 0) begin nmis++; $display("FAIL protocol: got %0d overlapping strobes want 0", viol); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
